// File: rtl/arm_mem_responder_pkg.sv
// Shared definitions for the word-addressed memory responder: FSM state
// encodings, the value returned on a faulted access and the wait counter width.
package arm_mem_responder_pkg;

  typedef enum logic [0:0] {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } ms_state_t;

  localparam logic [31:0] FAULT_RDATA = 32'h0000_0000;
  localparam int          CNT_W       = 4;

endpackage

// File: rtl/arm_mem_responder_word_ram.sv
// 2^DEPTH_LOG2 x 32 word array. Two write ports (A has priority over B when
// both hit the same word) and one registered read port that returns the
// contents as they were before the edge on which the read is sampled.
module word_ram #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [DEPTH_LOG2-1:0] addr_a,
  input  logic [31:0]           data_a,
  input  logic                  we_b,
  input  logic [DEPTH_LOG2-1:0] addr_b,
  input  logic [31:0]           data_b,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Port B first so a same-word port A write lands last and wins.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= data_b;
    if (we_a) mem[addr_a] <= data_a;
  end

  // Registered read; holds its value until the next enabled read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory responder at the far end of the core bus. Accepts one request at a
// time, waits WAIT_STATES cycles, then commits the access and pulses ack
// (with abort on misaligned or out-of-range addresses). A preload port lets
// the bench write instruction images at any time.
module arm_mem_responder
  import arm_mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 5,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  mreq,
  input  logic [31:0]           addr,
  input  logic                  w,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ack,
  output logic                  abort,
  output logic                  busy,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  ms_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, commit;

  logic [31:0]      addr_p0, wdata_p0;
  logic             w_p0;

  logic [31:0]      word_p0;
  logic             fault_p0;
  logic             ram_we, ram_re;
  logic [31:0]      ram_q;

  logic             sel_ram;
  logic [31:0]      rdata_hold;

  // Word index relative to BASE_ADDR; anything above the array or not word
  // aligned is a fault and never touches the array.
  always_comb begin
    word_p0  = (addr_p0 - BASE_ADDR) >> 2;
    fault_p0 = (addr_p0[1:0] != 2'b00) || (|word_p0[31:DEPTH_LOG2]);
  end

  // Next-state logic: accept in IDLE, count down in WAIT, commit when cnt hits 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      MS_IDLE: begin
        if (mreq) begin
          accept    = 1'b1;
          state_nxt = MS_WAIT;
          cnt_nxt   = CNT_W'(WAIT_STATES);
        end
      end
      MS_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          commit    = 1'b1;
          state_nxt = MS_IDLE;
        end
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  // State, counter and registered response outputs.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= MS_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      abort      <= 1'b0;
      sel_ram    <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == MS_WAIT);
      ack   <= commit;
      abort <= commit && fault_p0;
      if (commit) begin
        sel_ram    <= !w_p0 && !fault_p0;
        rdata_hold <= fault_p0 ? FAULT_RDATA : wdata_p0;
      end
    end
  end

  // Request capture; data only, so no reset.
  always_ff @(posedge clk1) begin
    if (accept) begin
      addr_p0  <= addr;
      w_p0     <= w;
      wdata_p0 <= wdata;
    end
  end

  // A reset on the commit edge suppresses the access entirely.
  always_comb begin
    ram_we = commit && w_p0 && !fault_p0 && !rst;
    ram_re = commit && !w_p0 && !fault_p0 && !rst;
  end

  word_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk1),
    .we_a   (ram_we),
    .addr_a (word_p0[DEPTH_LOG2-1:0]),
    .data_a (wdata_p0),
    .we_b   (ld_en),
    .addr_b (ld_addr),
    .data_b (ld_data),
    .rd_en  (ram_re),
    .rd_addr(word_p0[DEPTH_LOG2-1:0]),
    .rd_data(ram_q)
  );

  // Both sources are registers, so rdata stays free of input-to-output paths.
  assign rdata = sel_ram ? ram_q : rdata_hold;

endmodule

// File: tb/tb_arm_mem_responder.sv
// Directed bench for arm_mem_responder: one instance with two wait states
// and one with zero wait states, sharing clock and request inputs.
module tb_arm_mem_responder;

  localparam int WS = 2;

  logic        clk1 = 1'b0;
  logic        rst, mreq, w, ld_en;
  logic [31:0] addr, wdata, ld_data;
  logic [4:0]  ld_addr;

  logic [31:0] rdata2, rdata0;
  logic        ack2, abort2, busy2, ack0, abort0, busy0;

  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk1 = ~clk1;

  arm_mem_responder #(.DEPTH_LOG2(5), .WAIT_STATES(WS), .BASE_ADDR(32'h0)) dut (
    .clk1(clk1), .rst(rst), .mreq(mreq), .addr(addr), .w(w), .wdata(wdata),
    .rdata(rdata2), .ack(ack2), .abort(abort2), .busy(busy2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  arm_mem_responder #(.DEPTH_LOG2(5), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_z (
    .clk1(clk1), .rst(rst), .mreq(mreq), .addr(addr), .w(w), .wdata(wdata),
    .rdata(rdata0), .ack(ack0), .abort(abort0), .busy(busy0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Issue one request to the two-wait-state instance and check its response.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_ab, input string tag);
    int   n;
    logic got;
    mreq = 1'b1; w = wr; addr = a; wdata = d;
    step();
    mreq = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      if (ack2) got = 1'b1;
    end
    check_eq({tag, "_lat"}, n, WS + 1);
    check_eq({tag, "_rd"}, rdata2, exp_rd);
    check_eq({tag, "_ab"}, {31'b0, abort2}, {31'b0, exp_ab});
  endtask

  initial begin
    int acks;
    logic [31:0] cap;

    rst = 1'b1; mreq = 1'b0; w = 1'b0; addr = '0; wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) step();
    check_eq("rst_rdata", rdata2, 32'h0);
    check_eq("rst_ack",   {31'b0, ack2},   32'h0);
    check_eq("rst_abort", {31'b0, abort2}, 32'h0);
    check_eq("rst_busy",  {31'b0, busy2},  32'h0);
    rst = 1'b0;
    step();

    // Preload an image: two instruction words, the rest a known pattern.
    for (int i = 0; i < 32; i++) begin
      model[i] = (i == 0) ? 32'hE290_0F0F : (i == 1) ? 32'hE090_0001 : (32'hC0DE_0000 + i);
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = model[i];
      step();
    end
    ld_en = 1'b0;
    step();

    // Back-to-back reads: second request issued in the first ack cycle.
    do_req(1'b0, 32'h0, 32'h0, 32'hE290_0F0F, 1'b0, "rd0");
    do_req(1'b0, 32'h4, 32'h0, 32'hE090_0001, 1'b0, "rd4");

    do_req(1'b1, 32'h8, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, "wr8");
    model[2] = 32'hFFFF_FFF0;
    do_req(1'b0, 32'h8, 32'h0, 32'hFFFF_FFF0, 1'b0, "rd8");

    do_req(1'b0, 32'h2, 32'h0, 32'h0, 1'b1, "misalign");
    do_req(1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0, 1'b1, "oob_wr");
    for (int i = 0; i < 32; i++)
      do_req(1'b0, 32'(i * 4), 32'h0, model[i], 1'b0, $sformatf("scan%0d", i));

    // A second mreq during WAIT must be ignored.
    mreq = 1'b1; w = 1'b0; addr = 32'h4;
    step();
    mreq = 1'b0;
    check_eq("busy_wait", {31'b0, busy2}, 32'h1);
    step();
    mreq = 1'b1; addr = 32'h8;
    step();
    mreq = 1'b0;
    acks = 0; cap = '0;
    for (int i = 0; i < 10; i++) begin
      if (ack2) begin acks++; cap = rdata2; end
      step();
    end
    check_eq("busy_acks", acks, 1);
    check_eq("busy_rd", cap, model[1]);

    // Core write and preload to idx 3 on the same edge: core wins.
    mreq = 1'b1; w = 1'b1; addr = 32'hC; wdata = 32'h1;
    step();
    mreq = 1'b0;
    step();
    step();
    ld_en = 1'b1; ld_addr = 5'd3; ld_data = 32'h2;
    step();
    ld_en = 1'b0;
    check_eq("coll_ack", {31'b0, ack2}, 32'h1);
    check_eq("coll_echo", rdata2, 32'h1);
    model[3] = 32'h1;
    do_req(1'b0, 32'hC, 32'h0, 32'h1, 1'b0, "coll_rd");

    // Read and preload to idx 5 on the same edge: read sees old contents.
    mreq = 1'b1; w = 1'b0; addr = 32'h14;
    step();
    mreq = 1'b0;
    step();
    step();
    ld_en = 1'b1; ld_addr = 5'd5; ld_data = 32'h55;
    step();
    ld_en = 1'b0;
    check_eq("rcoll_ack", {31'b0, ack2}, 32'h1);
    check_eq("rcoll_old", rdata2, model[5]);
    model[5] = 32'h55;
    do_req(1'b0, 32'h14, 32'h0, 32'h55, 1'b0, "rcoll_new");

    // Reset one cycle after a write is accepted drops it.
    mreq = 1'b1; w = 1'b1; addr = 32'hC; wdata = 32'hAA;
    step();
    mreq = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rdata", rdata2, 32'h0);
    check_eq("mid_ack",   {31'b0, ack2},   32'h0);
    check_eq("mid_abort", {31'b0, abort2}, 32'h0);
    check_eq("mid_busy",  {31'b0, busy2},  32'h0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack2) acks++;
    end
    check_eq("mid_noack", acks, 0);
    do_req(1'b0, 32'hC, 32'h0, model[3], 1'b0, "mid_rd");

    // Zero wait states with mreq held: busy 1/0, ack on every other cycle.
    mreq = 1'b1; w = 1'b0; addr = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq($sformatf("z_busy%0d", k), {31'b0, busy0}, (k % 2 == 1) ? 32'h1 : 32'h0);
      check_eq($sformatf("z_ack%0d", k),  {31'b0, ack0},  (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k % 2 == 1) addr = 32'((k + 1) * 2);
      else check_eq($sformatf("z_rd%0d", k), rdata0, model[k / 2 - 1]);
    end
    mreq = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
